// File: rtl/mips_run_ctrl.sv
// Run controller for the pipelined MIPS core: holds the core in reset, then runs it
// while counting cycles and retires until a W-stage self-loop (halt) or a cycle limit.
module mips_run_ctrl #(
   parameter int unsigned RST_CYCLES  = 4,
   parameter int unsigned TIMEOUT     = 100000,
   parameter int unsigned HALT_REPEAT = 8,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             retire,
   input  logic [31:0]      pc_w,
   output logic             cpu_reset,
   output logic             running,
   output logic             done,
   output logic             timed_out,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instr_cnt,
   output logic [31:0]      halt_pc
);

   // state     | meaning
   // S_HOLD    | core held in reset for RST_CYCLES cycles
   // S_RUN     | core running, counters and halt detect active
   // S_HALTED  | self-loop seen at W, core frozen, done=1
   // S_TIMEOUT | cycle limit reached, core frozen, timed_out=1
   localparam logic [1:0] S_HOLD    = 2'd0;
   localparam logic [1:0] S_RUN     = 2'd1;
   localparam logic [1:0] S_HALTED  = 2'd2;
   localparam logic [1:0] S_TIMEOUT = 2'd3;

   localparam int HOLD_W = $clog2(RST_CYCLES + 1);
   localparam int STRK_W = $clog2(HALT_REPEAT + 1);

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
   localparam logic [STRK_W-1:0] STRK_MAX  = STRK_W'(HALT_REPEAT);
   localparam logic [STRK_W-1:0] STRK_ONE  = STRK_W'(1);
   localparam logic [63:0]       TO_LAST   = 64'(TIMEOUT) - 64'd1;
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic [HOLD_W-1:0] hold_cnt;
   logic [31:0]       last_pc;
   logic [31:0]       last_pc_nxt;
   logic [STRK_W-1:0] streak;
   logic [STRK_W-1:0] streak_nxt;
   logic              halt_hit;
   logic              to_hit;

   // streak==0 means no retire seen since RUN entry, so the next retire always loads
   always_comb begin
      streak_nxt  = streak;
      last_pc_nxt = last_pc;
      if (retire) begin
         if ((streak != '0) && (pc_w == last_pc)) begin
            if (streak != STRK_MAX)
               streak_nxt = streak + 1'b1;
         end else begin
            streak_nxt  = STRK_ONE;
            last_pc_nxt = pc_w;
         end
      end
   end

   assign halt_hit = retire && (streak_nxt == STRK_MAX);
   assign to_hit   = (64'(cycle_cnt) == TO_LAST);

   // halt is checked first so it wins when both fire on the same cycle
   always_comb begin
      state_nxt = state;
      case (state)
         S_HOLD: begin
            if (hold_cnt == HOLD_LAST)
               state_nxt = S_RUN;
         end
         S_RUN: begin
            if (halt_hit)
               state_nxt = S_HALTED;
            else if (to_hit)
               state_nxt = S_TIMEOUT;
         end
         default: state_nxt = state;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_HOLD;
         hold_cnt  <= '0;
         last_pc   <= '0;
         streak    <= '0;
         cpu_reset <= 1'b1;
         running   <= 1'b0;
         done      <= 1'b0;
         timed_out <= 1'b0;
         cycle_cnt <= '0;
         instr_cnt <= '0;
         halt_pc   <= '0;
      end else begin
         state     <= state_nxt;
         cpu_reset <= (state_nxt != S_RUN);
         running   <= (state_nxt == S_RUN);
         done      <= (state_nxt == S_HALTED);
         timed_out <= (state_nxt == S_TIMEOUT);

         if (state == S_HOLD)
            hold_cnt <= hold_cnt + 1'b1;

         if (state == S_RUN) begin
            if (cycle_cnt != CNT_MAX)
               cycle_cnt <= cycle_cnt + 1'b1;
            if (retire && (instr_cnt != CNT_MAX))
               instr_cnt <= instr_cnt + 1'b1;
            streak  <= streak_nxt;
            last_pc <= last_pc_nxt;
            if (halt_hit)
               halt_pc <= last_pc_nxt;
         end
      end
   end

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Bench for mips_run_ctrl: three instances (timeout 50, timeout 8, 4-bit counters)
// share stimulus; run scenarios come from a vector table, corner cases are hand-written.
module tb_mips_run_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        retire = 1'b0;
   logic [31:0] pc_w = 32'h0;

   logic        cpu_reset_a, running_a, done_a, timed_a;
   logic [31:0] cycle_a, instr_a, halt_pc_a;
   logic        cpu_reset_b, running_b, done_b, timed_b;
   logic [31:0] cycle_b, instr_b, halt_pc_b;
   logic        cpu_reset_c, running_c, done_c, timed_c;
   logic [3:0]  cycle_c, instr_c;
   logic [31:0] halt_pc_c;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mips_run_ctrl #(.RST_CYCLES(4), .TIMEOUT(50), .HALT_REPEAT(8), .CNT_W(32)) dut_a (
      .clk(clk), .reset(reset), .retire(retire), .pc_w(pc_w),
      .cpu_reset(cpu_reset_a), .running(running_a), .done(done_a), .timed_out(timed_a),
      .cycle_cnt(cycle_a), .instr_cnt(instr_a), .halt_pc(halt_pc_a));

   mips_run_ctrl #(.RST_CYCLES(4), .TIMEOUT(8), .HALT_REPEAT(8), .CNT_W(32)) dut_b (
      .clk(clk), .reset(reset), .retire(retire), .pc_w(pc_w),
      .cpu_reset(cpu_reset_b), .running(running_b), .done(done_b), .timed_out(timed_b),
      .cycle_cnt(cycle_b), .instr_cnt(instr_b), .halt_pc(halt_pc_b));

   mips_run_ctrl #(.RST_CYCLES(4), .TIMEOUT(100000), .HALT_REPEAT(8), .CNT_W(4)) dut_c (
      .clk(clk), .reset(reset), .retire(retire), .pc_w(pc_w),
      .cpu_reset(cpu_reset_c), .running(running_c), .done(done_c), .timed_out(timed_c),
      .cycle_cnt(cycle_c), .instr_cnt(instr_c), .halt_pc(halt_pc_c));

   typedef struct {
      int          n_pre;
      int          loop_n;
      bit          bubble;
      logic [31:0] base;
      logic        exp_done;
      logic        exp_to;
      logic [31:0] exp_hpc;
      int          exp_instr;
      int          exp_cycle;
   } vec_t;

   typedef struct {
      logic        r;
      logic [31:0] pc;
   } stim_t;

   vec_t vecs[6];
   vec_t sb[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
      end
   endtask

   // Pulse reset for one cycle, check reset values, then measure the hold length.
   // Retire stays high during the hold so any counting outside RUN is exposed.
   task automatic reset_and_hold();
      int n;
      reset = 1'b1;
      @(negedge clk);
      reset  = 1'b0;
      retire = 1'b1;
      pc_w   = 32'h3000;
      chk("rst_cpu_reset", 64'(cpu_reset_a), 64'd1);
      chk("rst_running", 64'(running_a), 64'd0);
      chk("rst_done", 64'(done_a), 64'd0);
      chk("rst_timed_out", 64'(timed_a), 64'd0);
      chk("rst_cycle_cnt", 64'(cycle_a), 64'd0);
      chk("rst_instr_cnt", 64'(instr_a), 64'd0);
      chk("rst_halt_pc", 64'(halt_pc_a), 64'd0);
      n = 0;
      while (cpu_reset_a && n < 20) begin
         n++;
         @(negedge clk);
      end
      chk("hold_len", 64'(n), 64'd4);
      chk("run_entry_running", 64'(running_a), 64'd1);
      chk("run_entry_cycle_cnt", 64'(cycle_a), 64'd0);
      chk("run_entry_instr_cnt", 64'(instr_a), 64'd0);
      retire = 1'b0;
   endtask

   task automatic apply(input vec_t v);
      stim_t st[$];
      stim_t s;
      vec_t  e;
      int    budget;
      for (int k = 0; k < v.n_pre; k++) begin
         s.r = 1'b1; s.pc = v.base + 32'(4 * k); st.push_back(s);
      end
      for (int j = 0; j < v.loop_n; j++) begin
         s.r = 1'b1; s.pc = v.base + 32'(4 * v.n_pre); st.push_back(s);
         if (v.bubble && j < v.loop_n - 1) begin
            s.r = 1'b0; s.pc = 32'hdead_beef; st.push_back(s);
         end
      end
      sb.push_back(v);
      reset_and_hold();
      budget = 0;
      while (!(done_a || timed_a) && budget < 300) begin
         if (st.size() > 0) begin
            s = st.pop_front();
            retire = s.r;
            pc_w   = s.pc;
         end else begin
            retire = 1'b0;
            pc_w   = 32'hdead_beef;
         end
         @(negedge clk);
         budget++;
      end
      retire = 1'b0;
      e = sb.pop_front();
      if (!(done_a || timed_a)) begin
         checks++;
         failures++;
         $display("FAIL vec_end_timeout actual=no_flag required=done_or_timed_out");
      end
      chk("vec_done", 64'(done_a), 64'(e.exp_done));
      chk("vec_timed_out", 64'(timed_a), 64'(e.exp_to));
      chk("vec_halt_pc", 64'(halt_pc_a), 64'(e.exp_hpc));
      chk("vec_instr_cnt", 64'(instr_a), 64'(e.exp_instr));
      chk("vec_cycle_cnt", 64'(cycle_a), 64'(e.exp_cycle));
      chk("vec_cpu_reset", 64'(cpu_reset_a), 64'd1);
      chk("vec_running", 64'(running_a), 64'd0);
      // final states must absorb further retires
      for (int k = 0; k < 3; k++) begin
         retire = 1'b1;
         pc_w   = 32'h7000 + 32'(4 * k);
         @(negedge clk);
      end
      retire = 1'b0;
      chk("frozen_instr_cnt", 64'(instr_a), 64'(e.exp_instr));
      chk("frozen_cycle_cnt", 64'(cycle_a), 64'(e.exp_cycle));
      chk("frozen_done", 64'(done_a), 64'(e.exp_done));
      chk("frozen_timed_out", 64'(timed_a), 64'(e.exp_to));
   endtask

   initial begin
      //          n_pre loop bub base         done to  hpc          instr cyc
      vecs[0] = '{3,    8,   1'b0, 32'h3000, 1'b1, 1'b0, 32'h300c, 11, 11};
      vecs[1] = '{0,    8,   1'b1, 32'h3010, 1'b1, 1'b0, 32'h3010,  8, 15};
      vecs[2] = '{60,   0,   1'b0, 32'h0000, 1'b0, 1'b1, 32'h0000, 50, 50};
      vecs[3] = '{2,    7,   1'b0, 32'h0100, 1'b0, 1'b1, 32'h0000,  9, 50};
      vecs[4] = '{0,    20,  1'b0, 32'h0200, 1'b1, 1'b0, 32'h0200,  8,  8};
      vecs[5] = '{0,    8,   1'b0, 32'h0000, 1'b1, 1'b0, 32'h0000,  8,  8};

      @(negedge clk);
      reset_and_hold();

      for (int i = 0; i < 6; i++)
         apply(vecs[i]);

      // reset mid-RUN, then again from HALTED
      reset_and_hold();
      for (int k = 0; k < 5; k++) begin
         retire = 1'b1;
         pc_w   = 32'h0800 + 32'(4 * k);
         @(negedge clk);
      end
      chk("midrun_running", 64'(running_a), 64'd1);
      chk("midrun_instr_cnt", 64'(instr_a), 64'd5);
      reset_and_hold();
      for (int k = 0; k < 8; k++) begin
         retire = 1'b1;
         pc_w   = 32'h0050;
         @(negedge clk);
      end
      retire = 1'b0;
      chk("halted_done", 64'(done_a), 64'd1);
      chk("halted_halt_pc", 64'(halt_pc_a), 64'h50);
      reset_and_hold();

      // 8th loop retire lands on the timeout cycle of instance b
      for (int k = 0; k < 8; k++) begin
         retire = 1'b1;
         pc_w   = 32'h4000;
         @(negedge clk);
         if (k == 6)
            chk("tie_pre_done", 64'(done_b), 64'd0);
      end
      retire = 1'b0;
      chk("tie_done", 64'(done_b), 64'd1);
      chk("tie_timed_out", 64'(timed_b), 64'd0);
      chk("tie_cycle_cnt", 64'(cycle_b), 64'd8);
      chk("tie_halt_pc", 64'(halt_pc_b), 64'h4000);

      // 4-bit counters saturate at 15
      reset_and_hold();
      for (int k = 0; k < 20; k++) begin
         retire = 1'b1;
         pc_w   = 32'h9000 + 32'(4 * k);
         @(negedge clk);
         if (k == 14) begin
            chk("sat15_cycle_cnt", 64'(cycle_c), 64'd15);
            chk("sat15_instr_cnt", 64'(instr_c), 64'd15);
         end
      end
      retire = 1'b0;
      chk("sat_cycle_cnt", 64'(cycle_c), 64'd15);
      chk("sat_instr_cnt", 64'(instr_c), 64'd15);
      chk("sat_running", 64'(running_c), 64'd1);
      chk("sat_done", 64'(done_c), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
